bcd_time_counter: RTL and testbench

- Parametrised BCD HH:MM:SS time-of-day / countdown counter with a built-in 1 Hz prescaler, for the clock display path.
- Successor to the MM:SS up/down counter. Adds an hours field, a 12/24-hour mode, free-running timekeeping from the system clock, per-field set without carry, and a countdown terminal flag.
- Drives the seven-segment digit mux directly with one 4-bit BCD digit per output.

---
 rtl/bcd_time_counter.sv | 186 ++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// BCD HH:MM:SS time-of-day / countdown counter with built-in one-second prescaler.
// Fields are stepped directly on BCD digit pairs so no non-BCD value can reach the outputs.
module bcd_time_counter #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter bit          MODE_12H = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       run_i,
  input  logic       count_down_i,
  input  logic [1:0] adj_sel_i,
  input  logic       adj_up_i,
  input  logic       adj_dn_i,
  output logic [3:0] sec_one_o,
  output logic [3:0] sec_ten_o,
  output logic [3:0] min_one_o,
  output logic [3:0] min_ten_o,
  output logic [3:0] hr_one_o,
  output logic [3:0] hr_ten_o,
  output logic       tick_o,
  output logic       done_o
);

  localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);
  localparam logic [3:0] HrTenRst = MODE_12H ? 4'd1 : 4'd0;
  localparam logic [3:0] HrOneRst = MODE_12H ? 4'd2 : 4'd0;

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    sec_one_q, sec_one_d, sec_ten_q, sec_ten_d;
  logic [3:0]    min_one_q, min_one_d, min_ten_q, min_ten_d;
  logic [3:0]    hr_one_q, hr_one_d, hr_ten_q, hr_ten_d;
  logic          tick_q, tick_d, done_q, done_d;

  // Returns {wrap, ten, one} for a 00..59 field.
  function automatic logic [8:0] step_sexa(input logic [3:0] ten, input logic [3:0] one,
                                           input logic dn);
    logic [8:0] r;
    r = {1'b0, ten, one};
    if (!dn) begin
      if (one == 4'd9) begin
        r[3:0] = 4'd0;
        if (ten == 4'd5) begin
          r[7:4] = 4'd0;
          r[8]   = 1'b1;
        end else begin
          r[7:4] = ten + 4'd1;
        end
      end else begin
        r[3:0] = one + 4'd1;
      end
    end else begin
      if (one == 4'd0) begin
        r[3:0] = 4'd9;
        if (ten == 4'd0) begin
          r[7:4] = 4'd5;
          r[8]   = 1'b1;
        end else begin
          r[7:4] = ten - 4'd1;
        end
      end else begin
        r[3:0] = one - 4'd1;
      end
    end
    return r;
  endfunction

  // Hours wrap 00..23, or 01..12 in 12-hour mode.
  function automatic logic [7:0] step_hour(input logic [3:0] ten, input logic [3:0] one,
                                           input logic dn);
    logic [7:0] r;
    r = {ten, one};
    if (!dn) begin
      if (MODE_12H && ten == 4'd1 && one == 4'd2)       r = {4'd0, 4'd1};
      else if (!MODE_12H && ten == 4'd2 && one == 4'd3) r = {4'd0, 4'd0};
      else if (one == 4'd9)                             r = {ten + 4'd1, 4'd0};
      else                                              r = {ten, one + 4'd1};
    end else begin
      if (MODE_12H && ten == 4'd0 && one == 4'd1)       r = {4'd1, 4'd2};
      else if (!MODE_12H && ten == 4'd0 && one == 4'd0) r = {4'd2, 4'd3};
      else if (one == 4'd0)                             r = {ten - 4'd1, 4'd9};
      else                                              r = {ten, one - 4'd1};
    end
    return r;
  endfunction

  logic       tick_edge, adj_ok, hold;
  logic [8:0] sec_t, min_t, sec_a, min_a;
  logic [7:0] hr_t, hr_a;

  always_comb begin
    tick_edge = run_i && (pre_q == PreMax);
    adj_ok    = (adj_sel_i != 2'd0) && (adj_up_i ^ adj_dn_i);
    hold      = done_q && count_down_i;

    sec_t = step_sexa(sec_ten_q, sec_one_q, count_down_i);
    min_t = step_sexa(min_ten_q, min_one_q, count_down_i);
    hr_t  = step_hour(hr_ten_q, hr_one_q, count_down_i);
    sec_a = step_sexa(sec_ten_q, sec_one_q, adj_dn_i);
    min_a = step_sexa(min_ten_q, min_one_q, adj_dn_i);
    hr_a  = step_hour(hr_ten_q, hr_one_q, adj_dn_i);

    pre_d     = pre_q;
    sec_one_d = sec_one_q;
    sec_ten_d = sec_ten_q;
    min_one_d = min_one_q;
    min_ten_d = min_ten_q;
    hr_one_d  = hr_one_q;
    hr_ten_d  = hr_ten_q;
    tick_d    = 1'b0;
    done_d    = done_q;

    if (run_i) pre_d = tick_edge ? '0 : pre_q + 1'b1;

    if (clear_i) begin
      pre_d     = '0;
      sec_one_d = 4'd0;
      sec_ten_d = 4'd0;
      min_one_d = 4'd0;
      min_ten_d = 4'd0;
      hr_one_d  = HrOneRst;
      hr_ten_d  = HrTenRst;
      done_d    = 1'b0;
    end else begin
      if (adj_ok) begin
        // An adjust wins over a coincident tick; the advance is dropped.
        case (adj_sel_i)
          2'd1: begin
            {sec_ten_d, sec_one_d} = sec_a[7:0];
            pre_d = '0;
          end
          2'd2:    {min_ten_d, min_one_d} = min_a[7:0];
          default: {hr_ten_d, hr_one_d} = hr_a;
        endcase
        done_d = 1'b0;
      end else if (tick_edge && !hold) begin
        tick_d = 1'b1;
        {sec_ten_d, sec_one_d} = sec_t[7:0];
        if (sec_t[8]) begin
          {min_ten_d, min_one_d} = min_t[7:0];
          if (min_t[8]) {hr_ten_d, hr_one_d} = hr_t;
        end
        if (count_down_i && !MODE_12H &&
            {hr_ten_d, hr_one_d, min_ten_d, min_one_d, sec_ten_d, sec_one_d} == 24'd0) begin
          done_d = 1'b1;
        end
      end
      if (!count_down_i) done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q     <= '0;
      sec_one_q <= 4'd0;
      sec_ten_q <= 4'd0;
      min_one_q <= 4'd0;
      min_ten_q <= 4'd0;
      hr_one_q  <= HrOneRst;
      hr_ten_q  <= HrTenRst;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      sec_one_q <= sec_one_d;
      sec_ten_q <= sec_ten_d;
      min_one_q <= min_one_d;
      min_ten_q <= min_ten_d;
      hr_one_q  <= hr_one_d;
      hr_ten_q  <= hr_ten_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign sec_one_o = sec_one_q;
  assign sec_ten_o = sec_ten_q;
  assign min_one_o = min_one_q;
  assign min_ten_o = min_ten_q;
  assign hr_one_o  = hr_one_q;
  assign hr_ten_o  = hr_ten_q;
  assign tick_o    = tick_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: 24h and 12h instances share stimulus and are compared each cycle
// against a seconds-of-day reference model.
module tb_bcd_time_counter;
  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst_n, clear, run, cd, up, dn;
  logic [1:0] sel;
  wire  [23:0] dig24, dig12;
  wire         tk24, tk12, dn24, dn12;

  bcd_time_counter #(.TICK_DIV(TD), .MODE_12H(1'b0)) u_dut24 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .run_i(run), .count_down_i(cd),
    .adj_sel_i(sel), .adj_up_i(up), .adj_dn_i(dn),
    .sec_one_o(dig24[3:0]), .sec_ten_o(dig24[7:4]), .min_one_o(dig24[11:8]),
    .min_ten_o(dig24[15:12]), .hr_one_o(dig24[19:16]), .hr_ten_o(dig24[23:20]),
    .tick_o(tk24), .done_o(dn24)
  );

  bcd_time_counter #(.TICK_DIV(TD), .MODE_12H(1'b1)) u_dut12 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .run_i(run), .count_down_i(cd),
    .adj_sel_i(sel), .adj_up_i(up), .adj_dn_i(dn),
    .sec_one_o(dig12[3:0]), .sec_ten_o(dig12[7:4]), .min_one_o(dig12[11:8]),
    .min_ten_o(dig12[15:12]), .hr_one_o(dig12[19:16]), .hr_ten_o(dig12[23:20]),
    .tick_o(tk12), .done_o(dn12)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: time as seconds since midnight (index 0 = 24h, 1 = 12h with 0 meaning 12).
  int mt[2];
  bit mtick[2];
  bit mdone[2];
  int mp;

  function automatic int hmod(input int i);
    return (i == 0) ? 24 : 12;
  endfunction

  function automatic logic [23:0] bcd6(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] to_bcd(input int t, input int hm);
    int h;
    h = t / 3600;
    if (hm == 12 && h == 0) h = 12;
    return bcd6(h, (t / 60) % 60, t % 60);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_rst();
    mp = 0;
    for (int i = 0; i < 2; i++) begin
      mt[i] = 0;
      mtick[i] = 1'b0;
      mdone[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit te, aok;
    int h, m, s, span, d, hm;
    te  = run && (mp == TD - 1);
    aok = (sel != 2'd0) && (up ^ dn);
    if (clear) begin
      model_rst();
      return;
    end
    if (run) mp = (mp + 1) % TD;
    if (aok && sel == 2'd1) mp = 0;
    for (int i = 0; i < 2; i++) begin
      hm   = hmod(i);
      span = hm * 3600;
      if (aok) begin
        d = up ? 1 : -1;
        h = mt[i] / 3600;
        m = (mt[i] / 60) % 60;
        s = mt[i] % 60;
        case (sel)
          2'd1:    s = (s + d + 60) % 60;
          2'd2:    m = (m + d + 60) % 60;
          default: h = (h + d + hm) % hm;
        endcase
        mt[i] = h * 3600 + m * 60 + s;
        mtick[i] = 1'b0;
        mdone[i] = 1'b0;
      end else if (te && !(mdone[i] && cd)) begin
        mt[i] = cd ? (mt[i] + span - 1) % span : (mt[i] + 1) % span;
        mtick[i] = 1'b1;
        if (cd && i == 0 && mt[i] == 0) mdone[i] = 1'b1;
      end else begin
        mtick[i] = 1'b0;
      end
      if (!cd) mdone[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("dig24", 32'(dig24), 32'(to_bcd(mt[0], 24)));
    chk("dig12", 32'(dig12), 32'(to_bcd(mt[1], 12)));
    chk("tick24", 32'(tk24), 32'(mtick[0]));
    chk("tick12", 32'(tk12), 32'(mtick[1]));
    chk("done24", 32'(dn24), 32'(mdone[0]));
    chk("done12", 32'(dn12), 32'(mdone[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic adj(input logic [1:0] s, input logic u, input logic d_, input int n);
    repeat (n) begin
      sel = s;
      up  = u;
      dn  = d_;
      cyc();
      sel = 2'd0;
      up  = 1'b0;
      dn  = 1'b0;
      cyc();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    clear = 1'b0;
    run   = 1'b0;
    cd    = 1'b0;
    sel   = 2'd0;
    up    = 1'b0;
    dn    = 1'b0;
    model_rst();
    #12;
    chk("rst24", 32'(dig24), 32'(bcd6(0, 0, 0)));
    chk("rst12", 32'(dig12), 32'(bcd6(12, 0, 0)));
    check_all();
    rst_n = 1'b1;

    // Free-running count up
    run = 1'b1;
    idle(4);
    chk("up4", 32'(dig24), 32'(bcd6(0, 0, 1)));
    idle(236);
    chk("up240", 32'(dig24), 32'(bcd6(0, 1, 0)));

    // Day rollover
    run = 1'b0;
    do_clear();
    adj(2'd3, 1'b0, 1'b1, 1);
    adj(2'd2, 1'b0, 1'b1, 1);
    adj(2'd1, 1'b0, 1'b1, 2);
    chk("set235958", 32'(dig24), 32'(bcd6(23, 59, 58)));
    run = 1'b1;
    idle(4);
    chk("roll1", 32'(dig24), 32'(bcd6(23, 59, 59)));
    idle(4);
    chk("roll2", 32'(dig24), 32'(bcd6(0, 0, 0)));

    // Countdown terminal
    run = 1'b0;
    do_clear();
    adj(2'd1, 1'b1, 1'b0, 2);
    cd  = 1'b1;
    run = 1'b1;
    idle(8);
    chk("cd_zero", 32'(dig24), 32'(bcd6(0, 0, 0)));
    chk("cd_done", 32'(dn24), 32'd1);
    idle(8);
    chk("cd_hold", 32'(dig24), 32'(bcd6(0, 0, 0)));
    run = 1'b0;
    adj(2'd1, 1'b1, 1'b0, 1);
    chk("cd_adj", 32'(dig24), 32'(bcd6(0, 0, 1)));
    chk("cd_adj_done", 32'(dn24), 32'd0);
    cd = 1'b0;

    // Per-field set, no carry
    do_clear();
    adj(2'd2, 1'b0, 1'b1, 1);
    adj(2'd1, 1'b0, 1'b1, 30);
    chk("set005930", 32'(dig24), 32'(bcd6(0, 59, 30)));
    adj(2'd2, 1'b1, 1'b0, 1);
    chk("min_nocarry", 32'(dig24), 32'(bcd6(0, 0, 30)));
    do_clear();
    adj(2'd1, 1'b0, 1'b1, 1);
    chk("sec_noborrow", 32'(dig24), 32'(bcd6(0, 0, 59)));

    // Adjust coinciding with a tick edge
    do_clear();
    run = 1'b1;
    for (int k = 0; k < 8 && mp != TD - 1; k++) cyc();
    sel = 2'd1;
    up  = 1'b1;
    cyc();
    sel = 2'd0;
    up  = 1'b0;
    chk("coll_time", 32'(dig24), 32'(bcd6(0, 0, 1)));
    chk("coll_tick", 32'(tk24), 32'd0);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tk24 && n < 10);
    chk("coll_gap", 32'(n), 32'd4);

    // 12-hour wrap points
    run = 1'b0;
    do_clear();
    chk("h12_clear", 32'(dig12), 32'(bcd6(12, 0, 0)));
    adj(2'd2, 1'b0, 1'b1, 1);
    adj(2'd1, 1'b0, 1'b1, 1);
    chk("h12_set", 32'(dig12), 32'(bcd6(12, 59, 59)));
    run = 1'b1;
    idle(4);
    chk("h12_up", 32'(dig12), 32'(bcd6(1, 0, 0)));
    cd = 1'b1;
    idle(4);
    chk("h12_dn", 32'(dig12), 32'(bcd6(12, 59, 59)));
    chk("h12_done", 32'(dn12), 32'd0);
    cd  = 1'b0;
    run = 1'b0;

    // Asynchronous reset mid-cycle, then clear beats adjust
    do_clear();
    adj(2'd3, 1'b1, 1'b0, 10);
    adj(2'd2, 1'b1, 1'b0, 20);
    adj(2'd1, 1'b1, 1'b0, 30);
    chk("set102030", 32'(dig24), 32'(bcd6(10, 20, 30)));
    run = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    model_rst();
    chk("arst24", 32'(dig24), 32'(bcd6(0, 0, 0)));
    chk("arst12", 32'(dig12), 32'(bcd6(12, 0, 0)));
    check_all();
    #1 rst_n = 1'b1;
    idle(4);
    chk("arst_restart", 32'(dig24), 32'(bcd6(0, 0, 1)));
    clear = 1'b1;
    sel   = 2'd1;
    up    = 1'b1;
    cyc();
    clear = 1'b0;
    sel   = 2'd0;
    up    = 1'b0;
    chk("clr_vs_adj", 32'(dig24), 32'(bcd6(0, 0, 0)));

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0) cd = ~cd;
      if ($urandom_range(0, 5) == 0) begin
        sel = 2'($urandom_range(0, 3));
        up  = 1'($urandom_range(0, 1));
        dn  = 1'($urandom_range(0, 1));
      end else begin
        sel = 2'd0;
        up  = 1'b0;
        dn  = 1'b0;
      end
      clear = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
